// File: rtl/sparce_pkg.sv
// Shared types for the SparCE skip engine: SASA entry layout, condition codes
// and the zero-condition helper used by the table's match logic.
package sparce_pkg;

  localparam int unsigned SP_NREGS        = 32;
  localparam int unsigned SP_REG_W        = $clog2(SP_NREGS);
  localparam int unsigned SP_ADDR_W       = 32;
  localparam int unsigned SP_SKIP_W       = 5;
  localparam int unsigned SP_SASA_ENTRIES = 16;

  typedef enum logic [1:0] {
    RS1_ZERO = 2'd0,
    RS2_ZERO = 2'd1,
    EITHER   = 2'd2,
    BOTH     = 2'd3
  } sasa_cond_t;

  typedef struct packed {
    logic                 valid;
    logic [SP_ADDR_W-1:0] pc;
    logic [SP_REG_W-1:0]  rs1;
    logic [SP_REG_W-1:0]  rs2;
    sasa_cond_t           cond;
    logic [SP_SKIP_W-1:0] skip;
  } sasa_entry_t;

  // Combine the effective-zero flags of both sources according to the entry's condition.
  function automatic logic cond_holds(sasa_cond_t c, logic z1, logic z2);
    logic r;
    r = 1'b0;
    case (c)
      RS1_ZERO: r = z1;
      RS2_ZERO: r = z2;
      EITHER:   r = z1 | z2;
      BOTH:     r = z1 & z2;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sparce_sasa_table.sv
// SASA table: programmable entry storage with a single write port and a
// parallel PC/condition match resolved by a lowest-index priority encoder.
module sparce_sasa_table
  import sparce_pkg::*;
#(
  parameter int unsigned ENTRIES = SP_SASA_ENTRIES,
  parameter int unsigned NREGS   = SP_NREGS,
  localparam int unsigned IDX_W  = $clog2(ENTRIES)
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  sasa_entry_t          wr_entry,
  input  logic                 lookup_valid,
  input  logic [SP_ADDR_W-1:0] lookup_pc,
  input  logic [NREGS-1:0]     zero_vec,
  output logic                 hit,
  output logic [SP_SKIP_W-1:0] hit_skip
);

  sasa_entry_t entries_q [ENTRIES];

  // Entry storage; a write lands at the clock edge so same-cycle lookups see old contents.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
    end else if (wr_en) begin
      entries_q[wr_idx] <= wr_entry;
    end
  end

  // Parallel match; the first matching entry from index 0 upward wins.
  always_comb begin
    hit      = 1'b0;
    hit_skip = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!hit && lookup_valid && entries_q[i].valid &&
          (entries_q[i].pc == lookup_pc) && (entries_q[i].skip != '0) &&
          cond_holds(entries_q[i].cond, zero_vec[entries_q[i].rs1],
                     zero_vec[entries_q[i].rs2])) begin
        hit      = 1'b1;
        hit_skip = entries_q[i].skip;
      end
    end
  end

endmodule

// File: rtl/sparce_skip_engine.sv
// SparCE skip engine top: sparsity register file, pending-write tracking,
// forwarded zero evaluation and the registered skip request to fetch.
module sparce_skip_engine
  import sparce_pkg::*;
#(
  parameter int unsigned NREGS        = SP_NREGS,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = SP_ADDR_W,
  parameter int unsigned SASA_ENTRIES = SP_SASA_ENTRIES,
  parameter int unsigned SKIP_W       = SP_SKIP_W,
  localparam int unsigned REG_W       = $clog2(NREGS),
  localparam int unsigned IDX_W       = $clog2(SASA_ENTRIES)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              id_rd_en,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  input  logic              sasa_wr_en,
  input  logic [IDX_W-1:0]  sasa_wr_idx,
  input  sasa_entry_t       sasa_wr_entry,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic              stall,
  output logic              skip_req,
  output logic [ADDR_W-1:0] skip_target,
  output logic [SKIP_W-1:0] skip_count
);

  logic [NREGS-1:0]  sprf_q, sprf_d;
  logic [NREGS-1:0]  pending_q, pending_d, pend_nf;
  logic [NREGS-1:0]  zero_vec;
  logic              hit;
  logic [SKIP_W-1:0] hit_skip;
  logic              skip_req_q, skip_req_d;
  logic [ADDR_W-1:0] skip_target_q, skip_target_d;
  logic [SKIP_W-1:0] skip_count_q, skip_count_d;

  // Next SpRF/pending state; the un-flushed next pending doubles as the forwarded
  // pending view for this cycle's lookup (a flush suppresses the request anyway).
  always_comb begin
    sprf_d  = sprf_q;
    pend_nf = pending_q;
    if (wb_en && (wb_rd != '0)) sprf_d[wb_rd] = (wb_data == '0);
    if (wb_en) pend_nf[wb_rd] = 1'b0;
    if (id_rd_en && (id_rd != '0)) pend_nf[id_rd] = 1'b1;
    sprf_d[0]  = 1'b1;
    pend_nf[0] = 1'b0;
    pending_d  = flush ? '0 : pend_nf;
    zero_vec   = sprf_d & ~pend_nf;
  end

  // Sparsity and pending registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sprf_q    <= '1;
      pending_q <= '0;
    end else begin
      sprf_q    <= sprf_d;
      pending_q <= pending_d;
    end
  end

  sparce_sasa_table #(
    .ENTRIES (SASA_ENTRIES),
    .NREGS   (NREGS)
  ) u_table (
    .CLK          (CLK),
    .nRST         (nRST),
    .wr_en        (sasa_wr_en),
    .wr_idx       (sasa_wr_idx),
    .wr_entry     (sasa_wr_entry),
    .lookup_valid (if_valid),
    .lookup_pc    (if_pc),
    .zero_vec     (zero_vec),
    .hit          (hit),
    .hit_skip     (hit_skip)
  );

  // Output next-state: flush kills the request, stall freezes everything, a miss holds target/count.
  always_comb begin
    skip_req_d    = skip_req_q;
    skip_target_d = skip_target_q;
    skip_count_d  = skip_count_q;
    if (flush) begin
      skip_req_d = 1'b0;
    end else if (!stall) begin
      skip_req_d = hit;
      if (hit) begin
        skip_target_d = if_pc + ((ADDR_W'(hit_skip) + ADDR_W'(1)) << 2);
        skip_count_d  = hit_skip;
      end
    end
  end

  // Registered skip outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      skip_req_q    <= 1'b0;
      skip_target_q <= '0;
      skip_count_q  <= '0;
    end else begin
      skip_req_q    <= skip_req_d;
      skip_target_q <= skip_target_d;
      skip_count_q  <= skip_count_d;
    end
  end

  assign skip_req    = skip_req_q;
  assign skip_target = skip_target_q;
  assign skip_count  = skip_count_q;

endmodule
